// File: rtl/dac_frame_tx.sv
// rtl/dac_frame_tx.sv - flow-controlled 16-bit serial DAC frame transmitter
// One-entry holding register feeds a SETUP/SHIFT/GAP serializer driving din/sync/sclk.
module dac_frame_tx #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic       clk,
  input  logic       aaa,
  input  logic       sample_valid,
  input  logic [7:0] sample_data,
  input  logic [1:0] pd_mode,
  output logic       sample_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       din,
  output logic       sync,
  output logic       sclk
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_TICKS - 1);

  state_t      state_q;
  logic [7:0]  div_q;
  logic [4:0]  bit_cnt_q;
  logic [3:0]  gap_cnt_q;
  logic [14:0] shift_q;
  logic [9:0]  hold_q;
  logic        full_q, full_d;
  logic        ready_q, busy_q, frame_done_q, din_q, sync_q, sclk_q;
  logic        tick, accept, load;
  logic [15:0] frame_w;

  assign tick    = (div_q == DIV_LAST);
  assign accept  = sample_valid & ready_q;
  assign load    = (state_q == ST_IDLE) & full_q;
  assign frame_w = {2'b00, hold_q, 4'b0000};

  // A same-edge accept and load keeps full set: the shifter takes the old entry.
  always_comb begin
    full_d = full_q;
    if (accept)    full_d = 1'b1;
    else if (load) full_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!aaa) begin
      state_q      <= ST_IDLE;
      div_q        <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      full_q       <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      din_q        <= 1'b0;
      sync_q       <= 1'b1;
      sclk_q       <= 1'b1;
    end else begin
      full_q       <= full_d;
      ready_q      <= ~full_d;
      frame_done_q <= 1'b0;
      if (accept) hold_q <= {pd_mode, sample_data};
      div_q <= tick ? 8'd0 : div_q + 8'd1;
      case (state_q)
        ST_IDLE: begin
          div_q <= '0;
          if (full_q) begin
            shift_q   <= frame_w[14:0];
            din_q     <= frame_w[15];
            sync_q    <= 1'b0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            div_q   <= '0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (sclk_q) begin
              sclk_q    <= 1'b0;
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end else begin
              sclk_q <= 1'b1;
              if (bit_cnt_q < 5'd16) begin
                din_q   <= shift_q[14];
                shift_q <= {shift_q[13:0], 1'b0};
              end else begin
                sync_q       <= 1'b1;
                din_q        <= 1'b0;
                frame_done_q <= 1'b1;
                gap_cnt_q    <= '0;
                div_q        <= '0;
                state_q      <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (gap_cnt_q == GAP_LAST) begin
              div_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              gap_cnt_q <= gap_cnt_q + 4'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sample_ready = ready_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign din          = din_q;
  assign sync         = sync_q;
  assign sclk         = sclk_q;

endmodule
